// File: rtl/dbg_trace_pkg.sv
// Shared definitions for the debug trace buffer: state encoding and pointer sizing.
package dbg_trace_pkg;

  // Capture controller states; the encoding is visible on the state output.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DUMP  = 2'd3;

  // Pointer width for a DEPTH-entry buffer (DEPTH is a power of two, >= 2).
  // Fill and read counters are PTR_W+1 bits (FILL_W) so they can hold DEPTH itself.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Sample storage for the trace buffer: one synchronous write port and one
// asynchronous read port, so a moved read pointer shows its entry in the same cycle.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 56,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Store one probe sample per enabled cycle.
  // NOTE: the array has no reset; entries are only read after a capture has
  // written them, and a reset-free array maps onto plain storage cells.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_trace_buffer.sv
// On-chip logic analyser: samples NUM_CH x WIDTH probe bits into a circular
// buffer, stops POST_TRIG samples after a mask/value trigger, then streams the
// captured window oldest-first over a valid/ready port.
module debug_trace_buffer
  import dbg_trace_pkg::*;
#(
  parameter int NUM_CH    = 7,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] probe,
  input  logic                    arm,
  input  logic                    force_trig,
  input  logic [NUM_CH*WIDTH-1:0] trig_mask,
  input  logic [NUM_CH*WIDTH-1:0] trig_value,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [NUM_CH*WIDTH-1:0] rd_data,
  output logic                    rd_last,
  output logic [1:0]              state,
  output logic                    triggered,
  output logic                    done
);

  localparam int DW     = NUM_CH * WIDTH;
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  POST_LOAD = PTR_W'(POST_TRIG);

  logic [1:0]        state_q,     state_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [FILL_W-1:0] fill_q,      fill_d;
  logic [PTR_W-1:0]  post_cnt_q,  post_cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [FILL_W-1:0] rd_cnt_q,    rd_cnt_d;
  logic              rd_valid_q,  rd_valid_d;
  logic              triggered_q, triggered_d;
  logic              done_q,      done_d;

  logic              trig_match;
  logic              capturing;
  logic              we;
  logic              enter_dump;
  logic [PTR_W-1:0]  wr_ptr_inc;
  logic [FILL_W-1:0] fill_inc;
  logic [DW-1:0]     ram_rdata;

  // An all-zero mask compares nothing and therefore matches every cycle.
  assign trig_match = (((probe ^ trig_value) & trig_mask) == '0) | force_trig;

  // Samples are stored in ARMED and POST; the arm cycle itself never writes.
  assign capturing  = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign we         = capturing & ~arm;

  // DEPTH is a power of two, so the pointer wraps by plain overflow.
  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (probe),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state logic: arm overrides everything, then capture, trigger and dump.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_cnt_d  = post_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    rd_valid_d  = rd_valid_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    enter_dump  = 1'b0;

    if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      fill_d      = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      rd_valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          wr_ptr_d = wr_ptr_inc;
          fill_d   = fill_inc;
          if (state_q == ST_ARMED) begin
            if (trig_match) begin
              triggered_d = 1'b1;
              post_cnt_d  = POST_LOAD;
              if (POST_TRIG == 0) begin
                enter_dump = 1'b1;
              end else begin
                state_d = ST_POST;
              end
            end
          end else begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == PTR_W'(1)) begin
              enter_dump = 1'b1;
            end
          end
          // Start the dump from the oldest entry, using the fill and pointer
          // values that include this cycle's write.
          if (enter_dump) begin
            state_d    = ST_DUMP;
            rd_ptr_d   = (fill_inc == FILL_MAX) ? wr_ptr_inc : '0;
            rd_cnt_d   = fill_inc;
            rd_valid_d = 1'b1;
          end
        end
        ST_DUMP: begin
          if (rd_valid_q && rd_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q - 1'b1;
            if (rd_cnt_q == FILL_W'(1)) begin
              state_d    = ST_IDLE;
              done_d     = 1'b1;
              rd_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Controller registers with asynchronous active-high reset.
  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign state     = state_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_valid_q & (rd_cnt_q == FILL_W'(1));
  assign rd_data   = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Bench for debug_trace_buffer: table-driven capture windows plus hand-written
// abort, reset and force-trigger sequences, checked through a dump scoreboard.
module tb_debug_trace_buffer;
  import dbg_trace_pkg::*;

  localparam int NUM_CH = 7;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int DW     = NUM_CH * WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] probe, trig_mask, trig_value;
  logic          arm_a, arm_b, force_trig, rd_ready;

  logic          a_rd_valid, a_rd_last, a_triggered, a_done;
  logic [DW-1:0] a_rd_data;
  logic [1:0]    a_state;
  logic          b_rd_valid, b_rd_last, b_triggered, b_done;
  logic [DW-1:0] b_rd_data;
  logic [1:0]    b_state;

  always #5 clk = ~clk;

  debug_trace_buffer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .POST_TRIG(8)) dut_a (
    .clk(clk), .reset(reset), .probe(probe), .arm(arm_a), .force_trig(force_trig),
    .trig_mask(trig_mask), .trig_value(trig_value), .rd_valid(a_rd_valid),
    .rd_ready(rd_ready), .rd_data(a_rd_data), .rd_last(a_rd_last), .state(a_state),
    .triggered(a_triggered), .done(a_done)
  );

  debug_trace_buffer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .POST_TRIG(0)) dut_b (
    .clk(clk), .reset(reset), .probe(probe), .arm(arm_b), .force_trig(force_trig),
    .trig_mask(trig_mask), .trig_value(trig_value), .rd_valid(b_rd_valid),
    .rd_ready(rd_ready), .rd_data(b_rd_data), .rd_last(b_rd_last), .state(b_state),
    .triggered(b_triggered), .done(b_done)
  );

  // Observed DUT selected by mon_sel (0 = POST_TRIG 8, 1 = POST_TRIG 0).
  logic          mon_sel;
  logic          m_valid, m_last, m_trig, m_done, m_arm;
  logic [DW-1:0] m_data;
  logic [1:0]    m_state;
  assign m_valid = mon_sel ? b_rd_valid  : a_rd_valid;
  assign m_last  = mon_sel ? b_rd_last   : a_rd_last;
  assign m_trig  = mon_sel ? b_triggered : a_triggered;
  assign m_done  = mon_sel ? b_done      : a_done;
  assign m_data  = mon_sel ? b_rd_data   : a_rd_data;
  assign m_state = mon_sel ? b_state     : a_state;
  assign m_arm   = mon_sel ? arm_b       : arm_a;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] value;
    int         ready_mode;
    logic [7:0] first;
    int         n;
  } vec_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            hs_count = 0;
  int            s_idx = 0;
  int            cyc = 0;
  int            ready_mode = 0;
  logic          stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;
  vec_t          vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Probe pattern for sample index s: channel 0 is a byte ramp, other channels
  // carry distinct bytes derived from it so whole-word compares are meaningful.
  function automatic logic [DW-1:0] ramp(input int s);
    logic [DW-1:0] r;
    logic [7:0]    b;
    b = 8'(s & 255);
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == 0) r[c*WIDTH +: WIDTH] = b;
      else        r[c*WIDTH +: WIDTH] = (b ^ 8'(c * 8'h35)) + 8'(c);
    end
    return r;
  endfunction

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    arm_a      = 1'b0;
    arm_b      = 1'b0;
    force_trig = 1'b0;
    s_idx++;
    probe = ramp(s_idx);
    cyc++;
    rd_ready = (ready_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  // Pulse arm on the selected DUT; the first stored sample is ramp(start).
  task automatic start_capture(input logic sel, input logic [7:0] m, input logic [7:0] v,
                               input int rmode, input int start);
    mon_sel    = sel;
    trig_mask  = DW'(m);
    trig_value = DW'(v);
    ready_mode = rmode;
    hs_count   = 0;
    s_idx      = start - 1;
    probe      = ramp(s_idx);
    if (sel) arm_b = 1'b1;
    else     arm_a = 1'b1;
  endtask

  task automatic expect_window(input int first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = ramp(first + i);
      e.last = (i == n - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    step();
    while (!m_done && k < budget) begin
      step();
      k++;
    end
    check({name, "_done_in_time"}, m_done, 1'b1);
  endtask

  task automatic finish_checks(input string name, input int n);
    check({name, "_handshakes"}, hs_count, n);
    check({name, "_sb_left"}, sb_q.size(), 0);
    check({name, "_triggered"}, m_trig, 1'b1);
    check({name, "_state_idle"}, m_state, ST_IDLE);
    check({name, "_valid_low"}, m_valid, 1'b0);
    sb_q.delete();
  endtask

  // Dump monitor: looks at the upcoming edge from the falling edge before it.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid_held", m_valid, 1'b1);
        check("stall_data_held", m_data, stall_data);
      end
      if (!m_valid) check("data_zero_when_invalid", m_data, '0);
      if (m_valid && rd_ready && !m_arm) begin
        hs_count++;
        check("entry_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("rd_data", m_data, mon_e.data);
          check("rd_last", m_last, mon_e.last);
        end
      end
      stall_pend <= m_valid && !rd_ready && !m_arm;
      stall_data <= m_data;
    end
  end

  initial begin
    vecs[0] = '{mask: 8'hFF, value: 8'h20, ready_mode: 0, first: 8'h19, n: 16}; // full window
    vecs[1] = '{mask: 8'hFF, value: 8'h02, ready_mode: 0, first: 8'h00, n: 11}; // early trigger
    vecs[2] = '{mask: 8'hFF, value: 8'h20, ready_mode: 1, first: 8'h19, n: 16}; // backpressure
    vecs[3] = '{mask: 8'h00, value: 8'h00, ready_mode: 0, first: 8'h00, n: 9};  // empty mask
    vecs[4] = '{mask: 8'hF0, value: 8'h10, ready_mode: 1, first: 8'h09, n: 16}; // partial mask, wrap
    vecs[5] = '{mask: 8'h0F, value: 8'h03, ready_mode: 0, first: 8'h00, n: 12}; // low-nibble mask

    mon_sel    = 1'b0;
    reset      = 1'b1;
    probe      = '0;
    trig_mask  = '0;
    trig_value = '0;
    arm_a      = 1'b0;
    arm_b      = 1'b0;
    force_trig = 1'b0;
    rd_ready   = 1'b1;

    // Reset state, then idle with a toggling probe.
    #2;
    check("rst_state", a_state, ST_IDLE);
    check("rst_valid", a_rd_valid, 1'b0);
    check("rst_data", a_rd_data, '0);
    check("rst_done", a_done, 1'b0);
    check("rst_trig", a_triggered, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      probe = DW'({$urandom, $urandom});
      check("idle_state", a_state, ST_IDLE);
      check("idle_valid", a_rd_valid, 1'b0);
    end

    // Table of capture windows on the POST_TRIG=8 instance.
    for (int i = 0; i < 6; i++) begin
      start_capture(1'b0, vecs[i].mask, vecs[i].value, vecs[i].ready_mode, 0);
      expect_window(vecs[i].first, vecs[i].n);
      wait_done($sformatf("vec%0d", i), 300);
      finish_checks($sformatf("vec%0d", i), vecs[i].n);
    end

    // POST_TRIG=0 with force_trig: one pre-trigger sample then the forced one.
    start_capture(1'b1, 8'hFF, 8'hFF, 0, 4);
    expect_window(4, 2);
    step();
    check("force_armed", b_state, ST_ARMED);
    step();
    force_trig = 1'b1;
    wait_done("force", 50);
    finish_checks("force", 2);

    // Reset between clock edges while in POST.
    start_capture(1'b0, 8'hFF, 8'h20, 0, 0);
    begin
      int k;
      k = 0;
      step();
      while (a_state != ST_POST && k < 100) begin
        step();
        k++;
      end
    end
    check("abort_reached_post", a_state, ST_POST);
    #1;
    reset = 1'b1;
    #1;
    check("abort_rst_state", a_state, ST_IDLE);
    check("abort_rst_valid", a_rd_valid, 1'b0);
    check("abort_rst_trig", a_triggered, 1'b0);
    check("abort_rst_data", a_rd_data, '0);
    check("abort_rst_last", a_rd_last, 1'b0);
    step();
    reset = 1'b0;

    // Re-arm during DUMP after three handshakes; the new capture must dump cleanly.
    start_capture(1'b0, 8'hFF, 8'h20, 0, 0);
    expect_window(8'h19, 16);
    begin
      int k;
      k = 0;
      step();
      while (hs_count < 3 && k < 100) begin
        step();
        k++;
      end
    end
    check("rearm_three_handshakes", hs_count, 3);
    sb_q.delete();
    start_capture(1'b0, 8'hFF, 8'h05, 0, 0);
    step();
    check("rearm_valid_dropped", a_rd_valid, 1'b0);
    check("rearm_state", a_state, ST_ARMED);
    check("rearm_done", a_done, 1'b0);
    expect_window(0, 14);
    wait_done("rearm", 300);
    finish_checks("rearm", 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
Parametrised on-chip logic analyser for the cpu debug ports. It samples NUM_CH probe channels of WIDTH bits each into a circular buffer of DEPTH entries. Capture stops a programmable number of samples after a mask/value trigger. The captured window is then streamed out oldest-first over a valid/ready interface. It sits beside cpu, driven by the debug_port buses, and replaces bench-side $display inspection with a synthesisable capture path.

Parameters:
NUM_CH, 7, number of probe channels (1..16)
WIDTH, 8, bits per channel
DEPTH, 16, buffer entries; power of two, >= 2
POST_TRIG, 8, samples captured after the trigger sample; 0..DEPTH-1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
probe  in  NUM_CH*WIDTH  concatenated channels; channel 0 in bits [WIDTH-1:0]
arm  in  1  one-cycle pulse; starts or restarts a capture
force_trig  in  1  unconditional trigger while ARMED
trig_mask  in  NUM_CH*WIDTH  1 = bit participates in trigger compare
trig_value  in  NUM_CH*WIDTH  compare value
rd_valid  out  1  rd_data holds a captured entry
rd_ready  in  1  consumer accepts the entry
rd_data  out  NUM_CH*WIDTH  captured sample
rd_last  out  1  qualifies the final entry of the dump
state  out  2  IDLE=0, ARMED=1, POST=2, DUMP=3
triggered  out  1  trigger seen this capture; sticky until next arm
done  out  1  dump completed; sticky until next arm

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wr_ptr=0, fill=0, post_cnt=0, rd_cnt=0. rd_valid, rd_data, rd_last, triggered and done are 0. Memory contents are not reset.
- Trigger match: ((probe ^ trig_value) & trig_mask) == 0, or force_trig=1. An all-zero mask therefore matches every cycle.
- IDLE: no writes. arm -> ARMED with wr_ptr=0, fill=0, triggered=0, done=0.
- ARMED: every cycle writes probe to mem[wr_ptr], increments wr_ptr modulo DEPTH and saturates fill at DEPTH. On a match, that same sample is written and counts as the trigger sample. triggered is set. post_cnt loads POST_TRIG. Next state is POST, or DUMP if POST_TRIG=0.
- POST: writes continue exactly as in ARMED. post_cnt decrements per write. The write made while post_cnt==1 is the last; next state is DUMP. Triggers are ignored.
- DUMP entry: rd_ptr = wr_ptr if fill==DEPTH, otherwise 0. rd_cnt = fill. rd_valid rises on the first DUMP cycle.
- DUMP: rd_data = mem[rd_ptr] and is held stable while rd_valid & !rd_ready. On a rd_valid & rd_ready handshake, rd_ptr increments modulo DEPTH and rd_cnt decrements. rd_last = rd_valid & (rd_cnt==1). The handshake on the last entry -> IDLE, done=1, rd_valid=0.
- rd_data is 0 whenever rd_valid=0.
- Entry count: min(pre-trigger samples + 1 + POST_TRIG, DEPTH). Early triggers give partial buffers.
- Wrap-around: wr_ptr and rd_ptr wrap silently. Overwriting oldest entries in ARMED is normal operation.
- arm priority: arm in any state aborts the current activity and restarts ARMED, including mid-DUMP (rd_valid drops the next cycle). No write occurs on the arm cycle. A trigger coincident with arm is ignored.
- reset mid-capture or mid-dump behaves exactly as initial reset. The next arm works normally.
- Latency: the sample present on cycle N while ARMED/POST is in memory at cycle N+1. The first rd_valid follows the final POST write by one cycle.

Decomposition:
- Package dbg_trace_pkg: state encoding constants (ST_IDLE, ST_ARMED, ST_POST, ST_DUMP), a PTR_W = clog2(DEPTH) helper function, and a FILL_W = PTR_W+1 note.
- Sub-module trace_ram: DEPTH x (NUM_CH*WIDTH) register array with one synchronous write port and one asynchronous read port.
- Control FSM, trigger compare and pointers stay in debug_trace_buffer.

Test Plan:
- Reset: assert reset mid-clock with no edge -> all outputs 0 and state=0 immediately; deassert; 10 idle cycles with probe toggling -> still IDLE, rd_valid=0.
- Full window (DEPTH=16, POST_TRIG=8): probe ch0 = ramp 0x00,0x01,..., mask ch0=0xFF, value=0x20, arm at ramp 0x00, rd_ready=1 -> 16 entries 0x19..0x28 in order; rd_last only with 0x28; done=1 afterwards.
- Early trigger: value=0x02 -> 11 entries 0x00..0x0A; rd_last on 0x0A; triggered=1.
- Backpressure: repeat the full-window case with rd_ready toggling 1,0,0,1,... -> rd_data stable through stalls; exactly 16 handshakes, no duplicates or drops.
- POST_TRIG=0 plus force_trig: force_trig one cycle after arm at ramp value 0x05 -> dump of 0x04,0x05 only (2 entries).
- Abort paths: reset during POST -> state=IDLE, rd_valid=0. arm during DUMP after 3 handshakes -> rd_valid=0 next cycle, state=ARMED, done=0; the new capture dumps correctly.
